// File: rtl/wb_regfile_if.sv
// Bundle between the MEM/WB register, the integer register file and decode.
// The slave modport is the register file's view; the master modport drives it.
interface wb_regfile_if #(
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int CNT_W = 64
);
  logic [XLEN-1:0]  wbpr_wb_write_back_data;
  logic [4:0]       wbpr_wb_write_back_addr;
  logic [XLEN-1:0]  wbpr_wb_now_pc;
  logic [ILEN-1:0]  wbpr_wb_instruction;
  logic             wbpr_wb_stall;
  logic             wbpr_wb_is_write_rf;
  logic [4:0]       id_rf_rs1_addr;
  logic [4:0]       id_rf_rs2_addr;
  logic [XLEN-1:0]  rf_id_rs1_data;
  logic [XLEN-1:0]  rf_id_rs2_data;
  logic             rf_retire_valid;
  logic [XLEN-1:0]  rf_retire_pc;
  logic [ILEN-1:0]  rf_retire_instr;
  logic [4:0]       rf_retire_rd;
  logic [XLEN-1:0]  rf_retire_wdata;
  logic [CNT_W-1:0] rf_instret;

  modport slave (
    input  wbpr_wb_write_back_data, wbpr_wb_write_back_addr, wbpr_wb_now_pc,
           wbpr_wb_instruction, wbpr_wb_stall, wbpr_wb_is_write_rf,
           id_rf_rs1_addr, id_rf_rs2_addr,
    output rf_id_rs1_data, rf_id_rs2_data, rf_retire_valid, rf_retire_pc,
           rf_retire_instr, rf_retire_rd, rf_retire_wdata, rf_instret
  );

  modport master (
    output wbpr_wb_write_back_data, wbpr_wb_write_back_addr, wbpr_wb_now_pc,
           wbpr_wb_instruction, wbpr_wb_stall, wbpr_wb_is_write_rf,
           id_rf_rs1_addr, id_rf_rs2_addr,
    input  rf_id_rs1_data, rf_id_rs2_data, rf_retire_valid, rf_retire_pc,
           rf_retire_instr, rf_retire_rd, rf_retire_wdata, rf_instret
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back commit into the 32 x XLEN integer register file, two combinational
// read ports, retire record and instret counter. Define WB_BYPASS_EN to forward
// same-cycle commit data to the read ports.
module wb_regfile #(
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int CNT_W = 64
) (
  input logic          sys_clk,
  input logic          sys_rst,
  wb_regfile_if.slave  bus
);

  logic            we;
  logic [XLEN-1:0] regs_q [32];

  logic [4:0]      rd_addr [2];
  logic [XLEN-1:0] rd_data [2];

  logic             retire_valid_q, retire_valid_d;
  logic [XLEN-1:0]  retire_pc_q,    retire_pc_d;
  logic [ILEN-1:0]  retire_instr_q, retire_instr_d;
  logic [4:0]       retire_rd_q,    retire_rd_d;
  logic [XLEN-1:0]  retire_wdata_q, retire_wdata_d;
  logic [CNT_W-1:0] instret_q,      instret_d;

  // Excluding index 0 here is what keeps x0 hard-wired to zero.
  assign we = bus.wbpr_wb_is_write_rf & ~bus.wbpr_wb_stall &
              (bus.wbpr_wb_write_back_addr != 5'd0);

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[bus.wbpr_wb_write_back_addr] <= bus.wbpr_wb_write_back_data;
    end
  end

  assign rd_addr[0] = bus.id_rf_rs1_addr;
  assign rd_addr[1] = bus.id_rf_rs2_addr;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
    always_comb begin
      rd_data[gi] = regs_q[rd_addr[gi]];
`ifdef WB_BYPASS_EN
      if (we && (rd_addr[gi] == bus.wbpr_wb_write_back_addr)) begin
        rd_data[gi] = bus.wbpr_wb_write_back_data;
      end
`endif
    end
  end

  assign bus.rf_id_rs1_data = rd_data[0];
  assign bus.rf_id_rs2_data = rd_data[1];

  // Bubbles clear the valid pulse but leave the last retire record visible.
  always_comb begin
    retire_valid_d = ~bus.wbpr_wb_stall;
    retire_pc_d    = retire_pc_q;
    retire_instr_d = retire_instr_q;
    retire_rd_d    = retire_rd_q;
    retire_wdata_d = retire_wdata_q;
    instret_d      = instret_q;
    if (!bus.wbpr_wb_stall) begin
      retire_pc_d    = bus.wbpr_wb_now_pc;
      retire_instr_d = bus.wbpr_wb_instruction;
      retire_rd_d    = we ? bus.wbpr_wb_write_back_addr : 5'd0;
      retire_wdata_d = we ? bus.wbpr_wb_write_back_data : '0;
      instret_d      = instret_q + CNT_W'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      retire_valid_q <= 1'b0;
      retire_pc_q    <= '0;
      retire_instr_q <= '0;
      retire_rd_q    <= '0;
      retire_wdata_q <= '0;
      instret_q      <= '0;
    end else begin
      retire_valid_q <= retire_valid_d;
      retire_pc_q    <= retire_pc_d;
      retire_instr_q <= retire_instr_d;
      retire_rd_q    <= retire_rd_d;
      retire_wdata_q <= retire_wdata_d;
      instret_q      <= instret_d;
    end
  end

  assign bus.rf_retire_valid = retire_valid_q;
  assign bus.rf_retire_pc    = retire_pc_q;
  assign bus.rf_retire_instr = retire_instr_q;
  assign bus.rf_retire_rd    = retire_rd_q;
  assign bus.rf_retire_wdata = retire_wdata_q;
  assign bus.rf_instret      = instret_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile; a second instance with a 4-bit counter
// exercises instret wrap-around.
module tb_wb_regfile;

  logic sys_clk;
  logic sys_rst;
  int   n_pass;
  int   n_total;

  wb_regfile_if #(.XLEN(32), .ILEN(32), .CNT_W(64)) u_if ();
  wb_regfile_if #(.XLEN(32), .ILEN(32), .CNT_W(4))  u_if_s ();

  wb_regfile #(.XLEN(32), .ILEN(32), .CNT_W(64)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (u_if.slave)
  );

  wb_regfile #(.XLEN(32), .ILEN(32), .CNT_W(4)) dut_s (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (u_if_s.slave)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic stall, input logic [4:0] addr,
                       input logic [31:0] data, input logic [31:0] pc, input logic [31:0] instr);
    u_if.wbpr_wb_is_write_rf     = wr;
    u_if.wbpr_wb_stall           = stall;
    u_if.wbpr_wb_write_back_addr = addr;
    u_if.wbpr_wb_write_back_data = data;
    u_if.wbpr_wb_now_pc          = pc;
    u_if.wbpr_wb_instruction     = instr;
  endtask

  task automatic edge_step();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    logic [31:0] collide_exp;
    n_pass  = 0;
    n_total = 0;
    sys_rst = 1'b0;
    drive(1'b0, 1'b1, 5'd0, 32'h0, 32'h0, 32'h0);
    u_if.id_rf_rs1_addr = 5'd0;
    u_if.id_rf_rs2_addr = 5'd0;
    u_if_s.wbpr_wb_is_write_rf     = 1'b0;
    u_if_s.wbpr_wb_stall           = 1'b1;
    u_if_s.wbpr_wb_write_back_addr = 5'd0;
    u_if_s.wbpr_wb_write_back_data = 32'h0;
    u_if_s.wbpr_wb_now_pc          = 32'h0;
    u_if_s.wbpr_wb_instruction     = 32'h0;
    u_if_s.id_rf_rs1_addr          = 5'd0;
    u_if_s.id_rf_rs2_addr          = 5'd0;

    // Reset state: all registers and retire outputs zero.
    repeat (2) @(posedge sys_clk);
    #1;
    for (int i = 0; i < 32; i++) begin
      u_if.id_rf_rs1_addr = 5'(i);
      u_if.id_rf_rs2_addr = 5'(31 - i);
      #1;
      check($sformatf("rst_rs1_x%0d", i), 64'(u_if.rf_id_rs1_data), 64'h0);
      check($sformatf("rst_rs2_x%0d", 31 - i), 64'(u_if.rf_id_rs2_data), 64'h0);
    end
    check("rst_instret", u_if.rf_instret, 64'h0);
    check("rst_valid", 64'(u_if.rf_retire_valid), 64'h0);

    @(negedge sys_clk);
    sys_rst = 1'b1;

    // Write x5.
    @(negedge sys_clk);
    drive(1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 32'h80000010, 32'h00A00293);
    u_if.id_rf_rs1_addr = 5'd5;
    edge_step();
    check("w5_rs1", 64'(u_if.rf_id_rs1_data), 64'hDEADBEEF);
    check("w5_valid", 64'(u_if.rf_retire_valid), 64'h1);
    check("w5_pc", 64'(u_if.rf_retire_pc), 64'h80000010);
    check("w5_instr", 64'(u_if.rf_retire_instr), 64'h00A00293);
    check("w5_rd", 64'(u_if.rf_retire_rd), 64'h5);
    check("w5_wdata", 64'(u_if.rf_retire_wdata), 64'hDEADBEEF);
    check("w5_instret", u_if.rf_instret, 64'h1);

    // Write to x0: dropped, still retires.
    @(negedge sys_clk);
    drive(1'b1, 1'b0, 5'd0, 32'h12345678, 32'h80000014, 32'h12345037);
    u_if.id_rf_rs1_addr = 5'd0;
    #1;
    check("w0_same_cycle_rs1", 64'(u_if.rf_id_rs1_data), 64'h0);
    edge_step();
    check("w0_rs1", 64'(u_if.rf_id_rs1_data), 64'h0);
    check("w0_valid", 64'(u_if.rf_retire_valid), 64'h1);
    check("w0_pc", 64'(u_if.rf_retire_pc), 64'h80000014);
    check("w0_rd", 64'(u_if.rf_retire_rd), 64'h0);
    check("w0_wdata", 64'(u_if.rf_retire_wdata), 64'h0);
    check("w0_instret", u_if.rf_instret, 64'h2);

    // Stalled write to x7: nothing commits or retires, record holds.
    @(negedge sys_clk);
    drive(1'b1, 1'b1, 5'd7, 32'h00000055, 32'h80000018, 32'h05500393);
    u_if.id_rf_rs1_addr = 5'd7;
    edge_step();
    check("stall_x7", 64'(u_if.rf_id_rs1_data), 64'h0);
    check("stall_valid", 64'(u_if.rf_retire_valid), 64'h0);
    check("stall_instret", u_if.rf_instret, 64'h2);
    check("stall_pc_hold", 64'(u_if.rf_retire_pc), 64'h80000014);
    check("stall_instr_hold", 64'(u_if.rf_retire_instr), 64'h12345037);

    // Non-writing instruction retires with rd/wdata zero.
    @(negedge sys_clk);
    drive(1'b0, 1'b0, 5'd7, 32'h00000099, 32'h8000001C, 32'h00000013);
    edge_step();
    check("nowr_x7", 64'(u_if.rf_id_rs1_data), 64'h0);
    check("nowr_valid", 64'(u_if.rf_retire_valid), 64'h1);
    check("nowr_rd", 64'(u_if.rf_retire_rd), 64'h0);
    check("nowr_wdata", 64'(u_if.rf_retire_wdata), 64'h0);
    check("nowr_instret", u_if.rf_instret, 64'h3);

    // x9 = 1, then collision write of A5A5A5A5 read on rs2.
    @(negedge sys_clk);
    drive(1'b1, 1'b0, 5'd9, 32'h00000001, 32'h80000020, 32'h00100493);
    u_if.id_rf_rs2_addr = 5'd9;
    edge_step();
    check("x9_init", 64'(u_if.rf_id_rs2_data), 64'h1);
    @(negedge sys_clk);
    drive(1'b1, 1'b0, 5'd9, 32'hA5A5A5A5, 32'h80000024, 32'hA5A5A4B7);
`ifdef WB_BYPASS_EN
    collide_exp = 32'hA5A5A5A5;
`else
    collide_exp = 32'h00000001;
`endif
    #1;
    check("collide_same_cycle", 64'(u_if.rf_id_rs2_data), 64'(collide_exp));
    check("b2b_valid_a", 64'(u_if.rf_retire_valid), 64'h1);
    edge_step();
    check("collide_next", 64'(u_if.rf_id_rs2_data), 64'hA5A5A5A5);
    check("b2b_valid_b", 64'(u_if.rf_retire_valid), 64'h1);
    check("collide_instret", u_if.rf_instret, 64'h5);

    // Back-to-back writes to x9: last write wins.
    @(negedge sys_clk);
    drive(1'b1, 1'b0, 5'd9, 32'h00000022, 32'h80000028, 32'h02200493);
    edge_step();
    check("lww_first", 64'(u_if.rf_id_rs2_data), 64'h22);
    @(negedge sys_clk);
    drive(1'b1, 1'b0, 5'd9, 32'h00000033, 32'h8000002C, 32'h03300493);
    edge_step();
    check("lww_last", 64'(u_if.rf_id_rs2_data), 64'h33);
    check("lww_rd", 64'(u_if.rf_retire_rd), 64'h9);
    check("lww_instret", u_if.rf_instret, 64'h7);

    // Asynchronous reset during a write to x3, held across an edge.
    @(negedge sys_clk);
    drive(1'b1, 1'b0, 5'd3, 32'h0000CAFE, 32'h80000030, 32'h000CA1B7);
    u_if.id_rf_rs1_addr = 5'd5;
    #2;
    sys_rst = 1'b0;
    #1;
    check("arst_valid", 64'(u_if.rf_retire_valid), 64'h0);
    check("arst_instret", u_if.rf_instret, 64'h0);
    check("arst_pc", 64'(u_if.rf_retire_pc), 64'h0);
    check("arst_x5", 64'(u_if.rf_id_rs1_data), 64'h0);
    u_if.id_rf_rs1_addr = 5'd3;
    edge_step();
    check("arst_x3", 64'(u_if.rf_id_rs1_data), 64'h0);
    check("arst_hold_valid", 64'(u_if.rf_retire_valid), 64'h0);

    // First edge after release is a normal commit.
    @(negedge sys_clk);
    drive(1'b1, 1'b0, 5'd3, 32'h00000077, 32'h80000034, 32'h07700193);
    sys_rst = 1'b1;
    edge_step();
    check("post_rst_x3", 64'(u_if.rf_id_rs1_data), 64'h77);
    check("post_rst_valid", 64'(u_if.rf_retire_valid), 64'h1);
    check("post_rst_instret", u_if.rf_instret, 64'h1);
    @(negedge sys_clk);
    drive(1'b0, 1'b1, 5'd0, 32'h0, 32'h0, 32'h0);

    // Counter wrap on the 4-bit instance.
    u_if_s.wbpr_wb_stall = 1'b0;
    repeat (15) @(posedge sys_clk);
    #1;
    check("wrap_allones", 64'(u_if_s.rf_instret), 64'hF);
    edge_step();
    check("wrap_zero", 64'(u_if_s.rf_instret), 64'h0);
    check("wrap_valid", 64'(u_if_s.rf_retire_valid), 64'h1);
    @(negedge sys_clk);
    u_if_s.wbpr_wb_stall = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the write-back pipeline register: accepts the WB-stage bundle and commits results into the 32-entry integer register file.
- Serves two combinational read ports to decode.
- Emits a registered retire record and a 64-bit retired-instruction counter for debug and perf.
- Sits between the MEM/WB register outputs and the ID stage.

Parameters:
- XLEN, 32, data and PC width.
- ILEN, 32, instruction width.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- sys_clk  in  1  single clock; all state updates on the rising edge.
- sys_rst  in  1  reset, asynchronous, active-low.
- wbpr_wb_write_back_data  in  XLEN  result to commit.
- wbpr_wb_write_back_addr  in  5  destination register index.
- wbpr_wb_now_pc  in  XLEN  PC of the WB-stage instruction.
- wbpr_wb_instruction  in  ILEN  instruction word in WB.
- wbpr_wb_stall  in  1  1 = WB slot holds a bubble; no commit, no retire.
- wbpr_wb_is_write_rf  in  1  instruction writes the register file.
- id_rf_rs1_addr  in  5  read port 1 index.
- id_rf_rs2_addr  in  5  read port 2 index.
- rf_id_rs1_data  out  XLEN  read port 1 data, combinational.
- rf_id_rs2_data  out  XLEN  read port 2 data, combinational.
- rf_retire_valid  out  1  registered pulse, one per retired instruction.
- rf_retire_pc  out  XLEN  PC of the retired instruction.
- rf_retire_instr  out  ILEN  instruction word retired.
- rf_retire_rd  out  5  destination committed; 0 if none.
- rf_retire_wdata  out  XLEN  value committed; 0 if none.
- rf_instret  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (sys_rst=0, asynchronous):
  - All 32 registers clear to 0.
  - rf_retire_valid, rf_retire_pc, rf_retire_instr, rf_retire_rd, rf_retire_wdata and rf_instret clear to 0.
  - Reset asserted mid-operation discards the in-flight commit; the first edge after release behaves as a normal cycle.
- Commit enable: we = wbpr_wb_is_write_rf & ~wbpr_wb_stall & (wbpr_wb_write_back_addr != 0).
  - On the rising edge with we=1: reg[addr] <= write_back_data.
  - At most one write per cycle.
- x0:
  - Never written; reads of index 0 always return 0, including while a write targets index 0.
  - A write with addr=0 and is_write_rf=1 is dropped silently but still retires.
- Reads:
  - Purely combinational from the array; no added latency.
  - A read of register N in cycle T observes writes committed at edges up to and including the start of T.
  - Same-cycle write/read collision is governed by WB_BYPASS_EN.
- Retire (sampled each edge, visible in the following cycle, latency 1):
  - When stall=0: rf_retire_valid <= 1; pc and instr are captured from the inputs; rd <= (we ? addr : 0); wdata <= (we ? data : 0).
  - When stall=1: rf_retire_valid <= 0; the other retire fields hold their previous values.
  - A bubble never retires, even if is_write_rf=1.
- Counter:
  - rf_instret increments by 1 on each edge with stall=0.
  - Wraps from all-ones to 0 with no flag.
  - The increment takes effect on the same edge as rf_retire_valid assertion, so counter and pulse stay aligned.
- Back-to-back:
  - Consecutive non-stalled cycles each retire; rf_retire_valid stays high continuously.
  - Consecutive writes to the same rd are last-write-wins.
- No backpressure: the block always accepts the WB bundle; stall is the only qualifier.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - Each read port forwards the commit data combinationally when we=1 and the read index equals wbpr_wb_write_back_addr (index != 0).
  - Decode therefore sees the value being written in the same cycle.
- Undefined:
  - Read ports return only the array contents, i.e. the pre-write value during a collision.
  - The hazard unit must cover the extra cycle.
- x0 behaviour and retire behaviour are identical in both builds.

Test Plan:
- Reset, then read all 32 indices -> every rs1/rs2 read returns 0; rf_instret=0; rf_retire_valid=0.
- Write addr=5 data=0xDEADBEEF, is_write_rf=1, stall=0, pc=0x80000010 -> next cycle: rs1_addr=5 reads 0xDEADBEEF; rf_retire_valid=1, rf_retire_pc=0x80000010, rf_retire_rd=5, rf_instret=1.
- Write addr=0 data=0x12345678 -> rs1_addr=0 still reads 0; rf_retire_rd=0, rf_retire_wdata=0; rf_instret increments.
- stall=1 with is_write_rf=1, addr=7, data=0x55 -> x7 is unchanged; rf_retire_valid=0; rf_instret is unchanged.
- Collision: write addr=9 data=0xA5A5A5A5 while rs2_addr=9, x9 previously 0x1 -> same cycle rs2 reads 0xA5A5A5A5 with WB_BYPASS_EN defined, 0x1 without it; both builds read 0xA5A5A5A5 the next cycle.
- Preload rf_instret to all-ones via a forced counter, then one non-stalled cycle -> rf_instret=0. Separately, pulse sys_rst low between clock edges during a write -> outputs clear immediately and the written register stays 0.
